switch_alloc_rr: RTL and testbench

Parametrised switch allocator and crossbar for the mesh router: NPORTS input ports, NPORTS output ports, single-flit packets with one-hot route labels. Each output port has its own round-robin arbiter and a registered output stage that holds under downstream backpressure. It sits between the route-compute/input-FIFO stage and the output links. It replaces the fixed four-port allocator with hard-wired arbitration.

---
 rtl/switch_alloc_rr_if.sv | 25 ++
 rtl/switch_alloc_rr.sv | 141 ++++++++++++++
 tb/tb_switch_alloc_rr.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_alloc_rr_if.sv
// Handshake/bus bundle between the input stage, switch_alloc_rr and the output links.
// Flit and route fields use the flat packed layout of the original allocator ports.
interface switch_alloc_rr_if #(
  parameter int unsigned NPORTS   = 5,
  parameter int unsigned DATASIZE = 40
) ();
  logic [NPORTS*NPORTS-1:0]   in_req;
  logic [NPORTS*DATASIZE-1:0] in_data;
  logic [NPORTS-1:0]          out_full;
  logic [NPORTS*NPORTS-1:0]   grant;
  logic [NPORTS-1:0]          in_ready;
  logic [NPORTS-1:0]          out_valid;
  logic [NPORTS*DATASIZE-1:0] out_data;
  logic                       err_flag;

  modport master (
    output in_req, in_data, out_full,
    input  grant, in_ready, out_valid, out_data, err_flag
  );

  modport slave (
    input  in_req, in_data, out_full,
    output grant, in_ready, out_valid, out_data, err_flag
  );
endinterface

// File: rtl/switch_alloc_rr.sv
// NPORTS x NPORTS single-flit switch allocator + crossbar with registered outputs.
// SWITCH_ALLOC_RR_EN defined: round-robin per output; undefined: fixed priority (lowest input wins).
module switch_alloc_rr #(
  parameter int unsigned NPORTS     = 5,
  parameter int unsigned DATASIZE   = 40,
  parameter int unsigned LOCAL_PORT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_alloc_rr_if.slave bus
);
  localparam int unsigned PW = $clog2(NPORTS);

  logic [NPORTS-1:0]   w_label   [NPORTS];
  logic [DATASIZE-1:0] w_flit    [NPORTS];
  logic [NPORTS-1:0]   w_idle;
  logic [NPORTS-1:0]   w_onehot;
  logic [NPORTS-1:0]   w_multi;
  logic [NPORTS-1:0]   w_load_en;
  logic [NPORTS-1:0]   w_win_vld;
  logic [PW-1:0]       w_win_idx [NPORTS];
  logic [NPORTS-1:0]   w_grant   [NPORTS];
  logic [NPORTS-1:0]   w_granted;

  logic [NPORTS-1:0]   r_valid;
  logic [DATASIZE-1:0] r_data    [NPORTS];
  logic                r_err;
`ifdef SWITCH_ALLOC_RR_EN
  logic [PW-1:0]       r_ptr     [NPORTS];
`endif

  // Label/flit unpacking and label classification
  always_comb begin
    for (int unsigned i = 0; i < NPORTS; i++) begin
      w_label[i]  = bus.in_req[i*NPORTS +: NPORTS];
      w_flit[i]   = bus.in_data[i*DATASIZE +: DATASIZE];
      w_idle[i]   = ~|w_label[i];
      w_onehot[i] = $onehot(w_label[i]);
      w_multi[i]  = ~w_idle[i] & ~w_onehot[i];
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NPORTS; o++) begin
      w_load_en[o] = (o == LOCAL_PORT) | ~bus.out_full[o];
    end
  end

  // Per-output arbiter: first valid candidate from the search start, wrapping
  always_comb begin
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    idx = '0;
    sum = '0;
    for (int unsigned o = 0; o < NPORTS; o++) begin
      w_win_vld[o] = 1'b0;
      w_win_idx[o] = '0;
      for (int unsigned k = 0; k < NPORTS; k++) begin
`ifdef SWITCH_ALLOC_RR_EN
        sum = {1'b0, r_ptr[o]} + (PW+1)'(k);
        if (sum >= (PW+1)'(NPORTS)) begin
          sum = sum - (PW+1)'(NPORTS);
        end
        idx = sum[PW-1:0];
`else
        idx = PW'(k);
`endif
        if (!w_win_vld[o] && w_onehot[idx] && w_label[idx][o]) begin
          w_win_vld[o] = 1'b1;
          w_win_idx[o] = idx;
        end
      end
    end
  end

  // Grants are suppressed while the output register cannot load
  always_comb begin
    w_granted    = '0;
    bus.grant    = '0;
    bus.out_data = '0;
    for (int unsigned o = 0; o < NPORTS; o++) begin
      w_grant[o] = '0;
      if (w_load_en[o] && w_win_vld[o]) begin
        w_grant[o][w_win_idx[o]] = 1'b1;
      end
      w_granted                            = w_granted | w_grant[o];
      bus.grant[o*NPORTS +: NPORTS]        = w_grant[o];
      bus.out_data[o*DATASIZE +: DATASIZE] = r_data[o];
    end
    bus.in_ready = w_idle | w_multi | w_granted;
  end

  assign bus.out_valid = r_valid;
  assign bus.err_flag  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_err   <= 1'b0;
      for (int unsigned o = 0; o < NPORTS; o++) begin
        r_data[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NPORTS; o++) begin
        if (w_load_en[o]) begin
          r_valid[o] <= w_win_vld[o];
          if (w_win_vld[o]) begin
            r_data[o] <= w_flit[w_win_idx[o]];
          end
        end
      end
      if (|w_multi) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef SWITCH_ALLOC_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < NPORTS; o++) begin
        r_ptr[o] <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NPORTS; o++) begin
        if (w_grant[o] != '0) begin
          r_ptr[o] <= (w_win_idx[o] == PW'(NPORTS-1)) ? '0 : w_win_idx[o] + 1'b1;
        end
      end
    end
  end
`endif

  for (genvar o = 0; o < NPORTS; o++) begin : g_chk
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(w_grant[o]));
    a_stall_nogrant: assert property (@(posedge clk) disable iff (!rst_n)
      !w_load_en[o] |-> (w_grant[o] == '0));
  end

endmodule

// File: tb/tb_switch_alloc_rr.sv
// Scoreboard bench for switch_alloc_rr: directed stimulus queues cycle-tagged
// expectations; a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_switch_alloc_rr;
  localparam int unsigned N  = 5;
  localparam int unsigned D  = 40;
  localparam int unsigned LP = 0;

  typedef enum int {K_GRANT, K_RDY, K_OVALID, K_ODATA, K_ERR} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    int          idx;
    logic [63:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  int   win_seq [4];
  int   win_ptr;

  localparam logic [39:0] DA = 40'h12_3456_789A;
  localparam logic [39:0] FA = 40'hAA_0000_0001;
  localparam logic [39:0] FB = 40'hBB_0000_0002;
  localparam logic [39:0] FC = 40'hCC_0000_0003;

  switch_alloc_rr_if #(.NPORTS(N), .DATASIZE(D)) sa_if ();

  switch_alloc_rr #(.NPORTS(N), .DATASIZE(D), .LOCAL_PORT(LP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sa_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] cd(int i);
    return 40'h10_0000_0000 + 40'(i);
  endfunction

  function automatic logic [39:0] rd(int i);
    return 40'h50_0000_0000 + 40'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sa_if.in_req   = '0;
    sa_if.in_data  = '0;
    sa_if.out_full = '0;
  endtask

  task automatic set_req(int i, logic [4:0] lbl, logic [39:0] d);
    sa_if.in_req[i*N +: N]  = lbl;
    sa_if.in_data[i*D +: D] = d;
  endtask

  task automatic ex(int dly, kind_e k, int idx, logic [63:0] v);
    exp_t e;
    e.cyc  = cyc + dly;
    e.kind = k;
    e.idx  = idx;
    e.val  = v;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] actual(kind_e k, int idx);
    case (k)
      K_GRANT:  return 64'(sa_if.grant[idx*N +: N]);
      K_RDY:    return 64'(sa_if.in_ready);
      K_OVALID: return 64'(sa_if.out_valid);
      K_ODATA:  return 64'(sa_if.out_data[idx*D +: D]);
      default:  return 64'(sa_if.err_flag);
    endcase
  endfunction

  always @(negedge clk) begin
    int          i;
    logic [63:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        act = actual(sb[i].kind, sb[i].idx);
        n_checks++;
        if (sb[i].cyc == cyc && act == sb[i].val) begin
          n_pass++;
        end else begin
          $display("FAIL %s[%0d] cyc=%0d got=%h exp=%h (due cyc %0d)",
                   sb[i].kind.name(), sb[i].idx, cyc, act, sb[i].val, sb[i].cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
`ifdef SWITCH_ALLOC_RR_EN
    win_seq = '{1, 3, 4, 1};
    win_ptr = 3;
`else
    win_seq = '{1, 1, 1, 1};
    win_ptr = 1;
`endif
    rst_n = 1'b0;
    idle();
    tick();
    ex(0, K_OVALID, 0, 64'h0);
    ex(0, K_ERR,    0, 64'h0);
    ex(0, K_ODATA,  3, 64'h0);
    ex(0, K_ODATA,  0, 64'h0);
    tick();
    rst_n = 1'b1;

    // single transfer
    tick(); idle();
    set_req(2, 5'b01000, DA);
    ex(0, K_GRANT,  3, 64'b00100);
    ex(0, K_RDY,    0, 64'b11111);
    ex(1, K_OVALID, 0, 64'b01000);
    ex(1, K_ODATA,  3, 64'(DA));
    #1;
    n_checks++;
    if (sa_if.grant[3*N +: N] === 5'b00100) begin
      n_pass++;
    end else begin
      $display("FAIL direct grant[3] cyc=%0d got=%b exp=00100", cyc, sa_if.grant[3*N +: N]);
    end
    tick(); idle();
    ex(1, K_OVALID, 0, 64'h0);

    // contention on output 1
    for (int c = 0; c < 4; c++) begin
      tick(); idle();
      set_req(1, 5'b00010, cd(1));
      set_req(3, 5'b00010, cd(3));
      set_req(4, 5'b00010, cd(4));
      ex(0, K_GRANT,  1, 64'd1 << win_seq[c]);
      ex(0, K_RDY,    0, 64'b00101 | (64'd1 << win_seq[c]));
      ex(1, K_OVALID, 0, 64'b00010);
      ex(1, K_ODATA,  1, 64'(cd(win_seq[c])));
    end
    tick(); idle();
    set_req(1, 5'b00010, cd(1));
    set_req(3, 5'b00010, cd(3));
    ex(0, K_GRANT, 1, 64'd1 << win_ptr);
    ex(1, K_ODATA, 1, 64'(cd(win_ptr)));
    tick(); idle();

    // backpressure on output 2
    tick(); idle();
    set_req(4, 5'b00100, FA);
    ex(0, K_GRANT, 2, 64'b10000);
    for (int c = 0; c < 3; c++) begin
      tick(); idle();
      sa_if.out_full = 5'b00100;
      set_req(0, 5'b00100, FB);
      ex(0, K_GRANT,  2, 64'h0);
      ex(0, K_RDY,    0, 64'b11110);
      ex(0, K_ODATA,  2, 64'(FA));
      ex(0, K_OVALID, 0, 64'b00100);
    end
    tick(); idle();
    set_req(0, 5'b00100, FB);
    ex(0, K_GRANT,  2, 64'b00001);
    ex(0, K_RDY,    0, 64'b11111);
    ex(0, K_ODATA,  2, 64'(FA));
    ex(1, K_ODATA,  2, 64'(FB));
    ex(1, K_OVALID, 0, 64'b00100);
    tick(); idle();

    // local port ignores out_full
    tick(); idle();
    sa_if.out_full = '1;
    set_req(3, 5'b00001, FC);
    ex(0, K_GRANT,  0, 64'b01000);
    ex(0, K_RDY,    0, 64'b11111);
    ex(1, K_OVALID, 0, 64'b00001);
    ex(1, K_ODATA,  0, 64'(FC));
    ex(1, K_ODATA,  2, 64'(FB));
    #1;
    n_checks++;
    if (sa_if.grant[0 +: N] === 5'b01000) begin
      n_pass++;
    end else begin
      $display("FAIL direct grant[0] cyc=%0d got=%b exp=01000", cyc, sa_if.grant[0 +: N]);
    end

    // malformed label
    tick(); idle();
    set_req(0, 5'b00011, 40'hEE_0000_0000);
    set_req(2, 5'b00010, cd(2));
    ex(0, K_GRANT,  0, 64'h0);
    ex(0, K_GRANT,  1, 64'b00100);
    ex(0, K_RDY,    0, 64'b11111);
    ex(0, K_ERR,    0, 64'h0);
    ex(1, K_ERR,    0, 64'h1);
    ex(1, K_OVALID, 0, 64'b00010);
    #1;
    n_checks++;
    if (sa_if.in_ready[0] === 1'b1) begin
      n_pass++;
    end else begin
      $display("FAIL direct in_ready[0] cyc=%0d got=%b exp=1", cyc, sa_if.in_ready[0]);
    end
    tick(); idle();
    ex(1, K_ERR, 0, 64'h1);
    tick(); idle();

    // fill all outputs, then reset mid-operation
    tick(); idle();
    for (int i = 0; i < 5; i++) set_req(i, 5'(1 << i), rd(i));
    ex(1, K_OVALID, 0, 64'b11111);
    ex(1, K_ODATA,  4, 64'(rd(4)));
    tick();
    tick();
    #1 rst_n = 1'b0;
    ex(0, K_OVALID, 0, 64'h0);
    ex(0, K_ODATA,  4, 64'h0);
    ex(0, K_ODATA,  3, 64'h0);
    ex(0, K_ERR,    0, 64'h0);
    tick();
    rst_n = 1'b1;
    idle();
    tick(); idle();
    set_req(2, 5'b01000, cd(2));
    set_req(4, 5'b01000, cd(4));
    ex(0, K_GRANT, 3, 64'b00100);
    ex(0, K_RDY,   0, 64'b01111);
    ex(0, K_ERR,   0, 64'h0);
    ex(1, K_ODATA, 3, 64'(cd(2)));
    tick(); idle();
    tick();
    tick();

    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s[%0d] cyc=%0d got=unchecked exp=%h", sb[0].kind.name(),
               sb[0].idx, cyc, sb[0].val);
      void'(sb.pop_front());
    end
    if (n_pass != n_checks) begin
      $display("FAIL summary got=%0d exp=%0d", n_pass, n_checks);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
